// File: rtl/fib_pkg.sv
// Shared constants, state encoding and small index helpers for the Fibonacci-code
// (Zeckendorf) word generator and any bench or block that consumes its words.
package fib_pkg;

  localparam int CODE_W    = 4;
  localparam int IDX_W     = 3;
  localparam int NUM_CODES = 8;

  // All 4-bit words with no two adjacent ones, in ascending order.
  localparam logic [CODE_W-1:0] FIB_CODES [NUM_CODES] = '{
    4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] i,
                                                input logic             down);
    return down ? (i - IDX_W'(1)) : (i + IDX_W'(1));
  endfunction

  // True when stepping from i in the given direction crosses the list boundary.
  function automatic logic is_wrap_step(input logic [IDX_W-1:0] i,
                                        input logic             down);
    return down ? (i == '0) : (i == IDX_W'(NUM_CODES - 1));
  endfunction

  function automatic logic has_adjacent_ones(input logic [CODE_W-1:0] c);
    return (c & (c >> 1)) != '0;
  endfunction

endpackage

// File: rtl/fib_code_lut.sv
// Combinational index-to-word lookup into the Fibonacci-code list.
// Kept standalone so benches and neighbouring blocks can reuse the same table.
module fib_code_lut
  import fib_pkg::*;
(
  input  logic [IDX_W-1:0]  i_idx,
  output logic [CODE_W-1:0] o_code
);

  assign o_code = FIB_CODES[i_idx];

endmodule

// File: rtl/fib_code_gen.sv
// Fibonacci-code word generator: steps the code list up/down, one word per
// valid/ready handshake, with a TICK_DIV-cycle gap. FIB_SELFCHECK_EN adds a sticky checker.
module fib_code_gen
  import fib_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter bit ONESHOT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic              load,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] code,
  output logic [IDX_W-1:0]  idx,
  output logic              busy,
  output logic              wrap_pulse,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] CNT_INIT = 8'(TICK_DIV - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  w_code_nxt;
  logic               r_wrap;
  logic               r_done;
  logic               w_wrap_nxt;
  logic               w_done_nxt;
  logic               w_hs;
  logic               w_term;
  logic               w_load_ok;
  logic               w_start_ok;

  assign w_hs       = (r_state == PRESENT) && out_ready;
  assign w_term     = ONESHOT && is_wrap_step(r_idx, dir);
  assign w_load_ok  = (r_state == IDLE) && load;
  assign w_start_ok = (r_state == IDLE) && start && !stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          if (TICK_DIV <= 1) begin
            w_state_nxt = PRESENT;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt = PRESENT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      PRESENT: begin
        if (w_hs) begin
          if (w_term) begin
            w_state_nxt = IDLE;
          end else if (TICK_DIV <= 1) begin
            w_state_nxt = PRESENT;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Abort wins over everything, but a coincident handshake still advances idx below.
    if (stop) begin
      w_state_nxt = IDLE;
    end
  end

  // Index/flag datapath: load happens before a same-cycle start, so start uses the loaded idx.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_wrap_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_load_ok) begin
      w_idx_nxt = load_idx;
    end
    if (w_hs) begin
      if (w_term) begin
        w_done_nxt = 1'b1;
      end else begin
        w_idx_nxt  = idx_step(r_idx, dir);
        w_wrap_nxt = is_wrap_step(r_idx, dir);
      end
    end
  end

  // Looking up the next index keeps the registered code aligned with idx every cycle.
  fib_code_lut u_lut (
    .i_idx  (w_idx_nxt),
    .o_code (w_code_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_code <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_code <= w_code_nxt;
      r_wrap <= w_wrap_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_comb begin
    out_valid = (r_state == PRESENT);
    busy      = (r_state != IDLE);
  end

  assign code       = r_code;
  assign idx        = r_idx;
  assign wrap_pulse = r_wrap;
  assign done       = r_done;

`ifdef FIB_SELFCHECK_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (out_valid && has_adjacent_ones(r_code)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_code_gen.sv
// Directed bench for fib_code_gen: three instances (back-to-back, TICK_DIV=3, one-shot)
// share one set of inputs; each scenario checks only the instance it targets.
module tb_fib_code_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, dir, load, out_ready;
  logic [2:0] load_idx;

  logic       a_valid, a_busy, a_wrap, a_done, a_err;
  logic [3:0] a_code;
  logic [2:0] a_idx;
  logic       b_valid, b_busy, b_wrap, b_done, b_err;
  logic [3:0] b_code;
  logic [2:0] b_idx;
  logic       c_valid, c_busy, c_wrap, c_done, c_err;
  logic [3:0] c_code;
  logic [2:0] c_idx;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fib_code_gen #(.TICK_DIV(1), .ONESHOT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_idx(load_idx), .out_ready(out_ready), .out_valid(a_valid), .code(a_code),
    .idx(a_idx), .busy(a_busy), .wrap_pulse(a_wrap), .done(a_done), .err(a_err)
  );

  fib_code_gen #(.TICK_DIV(3), .ONESHOT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_idx(load_idx), .out_ready(out_ready), .out_valid(b_valid), .code(b_code),
    .idx(b_idx), .busy(b_busy), .wrap_pulse(b_wrap), .done(b_done), .err(b_err)
  );

  fib_code_gen #(.TICK_DIV(1), .ONESHOT(1'b1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_idx(load_idx), .out_ready(out_ready), .out_valid(c_valid), .code(c_code),
    .idx(c_idx), .busy(c_busy), .wrap_pulse(c_wrap), .done(c_done), .err(c_err)
  );

  typedef struct {
    logic       start, load, stop, dir, rdy;
    logic [2:0] lidx;
    logic       ev, eb, ew, ed;
    logic [2:0] ei;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic s, input logic l, input logic sp,
                              input logic d, input logic r, input logic [2:0] li,
                              input logic ev, input logic eb, input logic ew,
                              input logic ed, input logic [2:0] ei, input logic [3:0] ec);
    vec_t v;
    v.start = s;  v.load = l;  v.stop = sp; v.dir = d; v.rdy = r; v.lidx = li;
    v.ev = ev;    v.eb = eb;   v.ew = ew;   v.ed = ed; v.ei = ei;  v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; dir = 1'b0; load = 1'b0; out_ready = 1'b0; load_idx = 3'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // start, load, stop, dir, rdy, lidx  ->  valid, busy, wrap, done, idx, code
    tbl[0]  = mk(1,0,0,0,0,0, 1,1,0,0, 0, 0);
    tbl[1]  = mk(0,0,0,0,1,0, 1,1,0,0, 1, 1);
    tbl[2]  = mk(0,0,0,0,1,0, 1,1,0,0, 2, 2);
    tbl[3]  = mk(0,0,0,0,1,0, 1,1,0,0, 3, 4);
    tbl[4]  = mk(0,0,0,0,1,0, 1,1,0,0, 4, 5);
    tbl[5]  = mk(0,0,0,0,1,0, 1,1,0,0, 5, 8);
    tbl[6]  = mk(0,0,0,0,1,0, 1,1,0,0, 6, 9);
    tbl[7]  = mk(0,0,0,0,1,0, 1,1,0,0, 7, 10);
    tbl[8]  = mk(0,0,0,0,1,0, 1,1,1,0, 0, 0);
    tbl[9]  = mk(0,0,0,0,1,0, 1,1,0,0, 1, 1);
    tbl[10] = mk(0,0,1,0,0,0, 0,0,0,0, 1, 1);
    tbl[11] = mk(1,1,0,1,0,5, 1,1,0,0, 5, 8);
    tbl[12] = mk(0,0,0,1,1,0, 1,1,0,0, 4, 5);
    tbl[13] = mk(0,0,0,1,1,0, 1,1,0,0, 3, 4);
    tbl[14] = mk(0,0,0,1,1,0, 1,1,0,0, 2, 2);
    tbl[15] = mk(0,0,0,1,1,0, 1,1,0,0, 1, 1);
    tbl[16] = mk(0,0,0,1,1,0, 1,1,0,0, 0, 0);
    tbl[17] = mk(0,0,0,1,1,0, 1,1,1,0, 7, 10);
    tbl[18] = mk(0,0,0,0,0,0, 1,1,0,0, 7, 10);
    tbl[19] = mk(0,0,1,0,0,0, 0,0,0,0, 7, 10);
    tbl[20] = mk(1,1,0,0,0,2, 1,1,0,0, 2, 2);
    tbl[21] = mk(0,0,1,0,1,0, 0,0,0,0, 3, 4);
    tbl[22] = mk(1,0,1,0,0,0, 0,0,0,0, 3, 4);
    tbl[23] = mk(1,0,0,0,0,0, 1,1,0,0, 3, 4);
    tbl[24] = mk(1,1,0,0,0,6, 1,1,0,0, 3, 4);
    tbl[25] = mk(0,0,1,0,0,0, 0,0,0,0, 3, 4);

    reset = 1'b1;
    idle_inputs();
    #12;
    chk("rst_valid", 8'(a_valid), 8'd0);
    chk("rst_busy",  8'(a_busy),  8'd0);
    chk("rst_idx",   8'(a_idx),   8'd0);
    chk("rst_code",  8'(a_code),  8'd0);
    chk("rst_flags", {4'd0, a_wrap, a_done, a_err, b_busy}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back instance, table-driven
    for (int i = 0; i < 26; i++) begin
      start = tbl[i].start; load = tbl[i].load; stop = tbl[i].stop;
      dir = tbl[i].dir; out_ready = tbl[i].rdy; load_idx = tbl[i].lidx;
      step();
      chk($sformatf("v%0d_valid", i), 8'(a_valid), 8'(tbl[i].ev));
      chk($sformatf("v%0d_busy", i),  8'(a_busy),  8'(tbl[i].eb));
      chk($sformatf("v%0d_wrap", i),  8'(a_wrap),  8'(tbl[i].ew));
      chk($sformatf("v%0d_done", i),  8'(a_done),  8'(tbl[i].ed));
      chk($sformatf("v%0d_idx", i),   8'(a_idx),   8'(tbl[i].ei));
      chk($sformatf("v%0d_code", i),  8'(a_code),  8'(tbl[i].ec));
    end
    idle_inputs();
    chk("a_err", 8'(a_err), 8'd0);

    // TICK_DIV=3: latency from start and from handshake, hold under backpressure
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_e0_valid", 8'(b_valid), 8'd0);
    chk("t3_e0_busy",  8'(b_busy),  8'd1);
    step();
    chk("t3_e1_valid", 8'(b_valid), 8'd0);
    step();
    chk("t3_e2_valid", 8'(b_valid), 8'd1);
    chk("t3_e2_code",  8'(b_code),  8'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t3_hold%0d_code", k), {3'd0, b_valid, b_code}, 8'h10);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_hs_valid", 8'(b_valid), 8'd0);
    chk("t3_hs_idx",   8'(b_idx),   8'd1);
    chk("t3_hs_code",  8'(b_code),  8'd1);
    step();
    chk("t3_hs1_valid", 8'(b_valid), 8'd0);
    step();
    chk("t3_hs2_valid", 8'(b_valid), 8'd1);
    chk("t3_hs2_code",  8'(b_code),  8'd1);

    // Reset in the middle of WAIT clears everything without a clock edge
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rw_busy_pre", 8'(b_busy), 8'd1);
    chk("rw_idx_pre",  8'(b_idx),  8'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_busy",  8'(b_busy),  8'd0);
    chk("rw_valid", 8'(b_valid), 8'd0);
    chk("rw_idx",   8'(b_idx),   8'd0);
    chk("rw_code",  8'(b_code),  8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("rw_restart_valid", 8'(b_valid), 8'd1);
    chk("rw_restart_code",  8'(b_code),  8'd0);
    chk("b_err", 8'(b_err), 8'd0);

    // One-shot: 9, 10, then terminal handshake ends the run
    do_reset();
    load = 1'b1; load_idx = 3'd6; start = 1'b1; dir = 1'b0;
    step();
    load = 1'b0; start = 1'b0;
    chk("os_first_code", 8'(c_code), 8'd9);
    chk("os_first_valid", 8'(c_valid), 8'd1);
    out_ready = 1'b1;
    step();
    chk("os_second_code", 8'(c_code), 8'd10);
    chk("os_second_idx",  8'(c_idx),  8'd7);
    step();
    out_ready = 1'b0;
    chk("os_done",  8'(c_done),  8'd1);
    chk("os_busy",  8'(c_busy),  8'd0);
    chk("os_valid", 8'(c_valid), 8'd0);
    chk("os_idx",   8'(c_idx),   8'd7);
    chk("os_wrap",  8'(c_wrap),  8'd0);
    step();
    chk("os_done_clear", 8'(c_done), 8'd0);
    chk("c_err", 8'(c_err), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fib_code_gen.md
Name: fib_code_gen

Overview:
- Sequential generator of the 4-bit Fibonacci-code (Zeckendorf) words, i.e. words with no two adjacent ones: 0,1,2,4,5,8,9,10.
- Steps through that list up or down, one word per valid/ready handshake, with a programmable inter-word delay.
- Sits upstream of the Fibonacci-code recogniser and the BCD display path. Acts as the stimulus/producer end of that interface.

Parameters:
- TICK_DIV, 1, cycles from start or handshake to the next out_valid (>=1, <=255).
- ONESHOT, 0, 0 = wrap continuously; 1 = stop after presenting the terminal word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; honoured only in IDLE.
- stop  in  1  level/pulse; abort to IDLE from any state.
- dir  in  1  0 = up (idx+1), 1 = down (idx-1); sampled at the handshake.
- load  in  1  pulse; load idx from load_idx; honoured only in IDLE.
- load_idx  in  3  index 0..7 into the code list.
- out_ready  in  1  consumer ready.
- out_valid  out  1  code/idx valid.
- code  out  4  current Fibonacci-code word.
- idx  out  3  current list index.
- busy  out  1  state != IDLE.
- wrap_pulse  out  1  one-cycle pulse when an advance wraps.
- done  out  1  one-cycle pulse at ONESHOT completion.
- err  out  1  sticky self-check error (see Optional Feature).

Behaviour:
- Reset (async): state=IDLE; idx=0, code=0, out_valid=0, busy=0, wrap_pulse=0, done=0, err=0; delay counter=0.
- LUT, idx->code: 0->0, 1->1, 2->2, 3->4, 4->5, 5->8, 6->9, 7->10.
- code is registered and always equals LUT(idx) in the same cycle as idx.
- States:
  - IDLE: out_valid=0.
    - load loads idx. load+start in the same cycle: load first, then start from the loaded idx.
    - start: counter=TICK_DIV-1; next state is WAIT, or PRESENT if TICK_DIV=1.
  - WAIT: counter decrements; at 1 -> PRESENT.
  - PRESENT: out_valid=1; code/idx stable until the handshake (out_valid & out_ready).
- On handshake:
  - idx advances per dir, modulo 8.
  - wrap_pulse=1 next cycle on 7->0 (up) or 0->7 (down).
  - Next state is PRESENT (TICK_DIV=1, back-to-back, one word per cycle) or WAIT with counter=TICK_DIV-1.
- Latency: start or handshake at edge k -> out_valid high from cycle k+TICK_DIV.
- ONESHOT=1: a handshake on the terminal word (idx 7 up, idx 0 down) does not advance.
  - idx holds; state -> IDLE; done=1 for one cycle; no wrap_pulse.
- stop: state -> IDLE next edge; out_valid drops; idx holds.
  - stop coincident with a handshake: the handshake completes (idx advances) and the state is IDLE.
  - stop has priority over start.
- load/start outside IDLE are ignored. A dir change while presenting does not alter the held word.
- Reset mid-operation returns to IDLE immediately; any transfer in flight is lost.

Optional Feature:
- Macro FIB_SELFCHECK_EN.
  - Defined: in-block checker flags any presented code with adjacent ones (code & (code>>1) != 0) while out_valid=1. err sets and stays set until reset.
  - Undefined: err tied to 0; no checker logic.
- The port exists in both builds.

Decomposition:
- Package fib_pkg:
  - CODE_W=4, IDX_W=3, NUM_CODES=8.
  - Constant array FIB_CODES[8].
  - typedef enum state_t {IDLE, WAIT, PRESENT}.
- One sub-module fib_code_lut (combinational idx->code from FIB_CODES), reusable by benches.

Test Plan:
- TICK_DIV=1, ONESHOT=0: reset, start, out_ready=1, dir=0 for 9 handshakes -> codes 0,1,2,4,5,8,9,10,0 on consecutive cycles; wrap_pulse once after the 10->0 step; err=0.
- TICK_DIV=3: start at edge 0 -> out_valid first high at cycle 3; hold out_ready=0 for 5 cycles -> code=0 held; release -> next valid (code 1) 3 cycles after the handshake.
- load_idx=5 with load+start same cycle, dir=1 -> codes 8,5,4,2,1,0,10; wrap_pulse after 0->10.
- ONESHOT=1, load_idx=6, dir=0, start -> codes 9,10; after the 10 handshake: done pulse, busy=0, idx=7, no wrap_pulse.
- stop asserted with out_valid=1, out_ready=1 at idx=2 -> idx=3 (code 4), IDLE, out_valid=0; start while busy is ignored.
- Assert reset mid-WAIT -> all outputs zero asynchronously; restart -> sequence begins at code 0.
